// File: rtl/pac_move_ctrl_if.sv
// Maze-map query bus between the movement controller and the wall lookup.
interface pac_move_ctrl_if;
  logic       wall_req;
  logic [9:0] wall_x;
  logic [8:0] wall_y;
  logic       wall_ack;
  logic       wall_hit;

  modport master (output wall_req, wall_x, wall_y, input wall_ack, wall_hit);
  modport slave  (input wall_req, wall_x, wall_y, output wall_ack, wall_hit);
endinterface

// File: rtl/pac_move_ctrl.sv
// Pac-Man sprite movement controller: decodes keypad/PS/2 direction keys,
// and on each frame tick asks the maze map whether the next step is free
// before committing the new sprite position.
module pac_move_ctrl #(
  parameter int STEP        = 2,
  parameter int X_MAX       = 608,
  parameter int Y_MAX       = 448,
  parameter int X_INIT      = 30,
  parameter int Y_INIT      = 146,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kp_ready_i,
  input  logic [4:0]            kp_code_i,
  input  logic                  ps2_ready_i,
  input  logic [9:0]            ps2_data_i,
  input  logic                  tick_i,
  pac_move_ctrl_if.master       wall,
  output logic [9:0]            pac_x_o,
  output logic [8:0]            pac_y_o,
  output logic [1:0]            dir_o,
  output logic                  moving_o,
  output logic                  pos_upd_o
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] XMAX11 = 11'(X_MAX);
  localparam logic [10:0] YMAX11 = 11'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_QUERY, S_WAIT, S_COMMIT} state_t;

  state_t        state_q, state_d;
  logic          kp_rdy_q, ps2_rdy_q;
  logic [1:0]    dir_q, dir_d;
  logic          moving_q, moving_d;
  logic [9:0]    pac_x_q, pac_x_d, cand_x_q, cand_x_d;
  logic [8:0]    pac_y_q, pac_y_d, cand_y_q, cand_y_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic          kp_vld, ps2_vld, key_evt, kp_take;
  logic [1:0]    kp_dir, ps2_dir, key_dir;
  logic [10:0]   x_ext, y_ext, nx, ny;
  logic          unused_break_hi;

  assign unused_break_hi = ps2_data_i[9];

  // Decode both key sources; a valid keypad press outranks a same-cycle PS/2 press.
  always_comb begin
    kp_vld  = 1'b1;
    kp_dir  = 2'd0;
    ps2_vld = 1'b1;
    ps2_dir = 2'd0;
    case (kp_code_i)
      5'h0E:   kp_dir = 2'd0;
      5'h0C:   kp_dir = 2'd1;
      5'h09:   kp_dir = 2'd2;
      5'h11:   kp_dir = 2'd3;
      default: kp_vld = 1'b0;
    endcase
    case (ps2_data_i[7:0])
      8'h74:   ps2_dir = 2'd0;
      8'h6B:   ps2_dir = 2'd1;
      8'h75:   ps2_dir = 2'd2;
      8'h72:   ps2_dir = 2'd3;
      default: ps2_vld = 1'b0;
    endcase
    kp_take = kp_ready_i & ~kp_rdy_q & kp_vld;
    key_evt = kp_take | (ps2_ready_i & ~ps2_rdy_q & ~ps2_data_i[8] & ps2_vld);
    key_dir = kp_take ? kp_dir : ps2_dir;
  end

  // Candidate position one step along the current heading, clamped to the screen.
  always_comb begin
    x_ext = {1'b0, pac_x_q};
    y_ext = {2'b00, pac_y_q};
    nx    = x_ext;
    ny    = y_ext;
    case (dir_q)
      2'd0: nx = (x_ext + STEP11 > XMAX11) ? XMAX11 : x_ext + STEP11;
      2'd1: nx = (x_ext < STEP11) ? 11'd0 : x_ext - STEP11;
      2'd2: ny = (y_ext < STEP11) ? 11'd0 : y_ext - STEP11;
      default: ny = (y_ext + STEP11 > YMAX11) ? YMAX11 : y_ext + STEP11;
    endcase
  end

  // Next-state logic: query/wait/commit sequence, then key events override heading/moving.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    moving_d   = moving_q;
    pac_x_d    = pac_x_q;
    pac_y_d    = pac_y_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (tick_i && moving_q) state_d = S_QUERY;
      end
      S_QUERY: begin
        if (nx == x_ext && ny == y_ext) begin
          moving_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          cand_x_d   = nx[9:0];
          cand_y_d   = ny[8:0];
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wall.wall_ack) begin
          if (wall.wall_hit) begin
            moving_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            state_d = S_COMMIT;
          end
        end else if (wait_cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          // No answer from the map: assume blocked rather than walk through a wall.
          moving_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        pac_x_d = cand_x_q;
        pac_y_d = cand_y_q;
        state_d = S_IDLE;
      end
    endcase
    if (key_evt) begin
      dir_d    = key_dir;
      moving_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      kp_rdy_q   <= 1'b0;
      ps2_rdy_q  <= 1'b0;
      dir_q      <= 2'd0;
      moving_q   <= 1'b0;
      pac_x_q    <= 10'(X_INIT);
      pac_y_q    <= 9'(Y_INIT);
      cand_x_q   <= 10'(X_INIT);
      cand_y_q   <= 9'(Y_INIT);
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      kp_rdy_q   <= kp_ready_i;
      ps2_rdy_q  <= ps2_ready_i;
      dir_q      <= dir_d;
      moving_q   <= moving_d;
      pac_x_q    <= pac_x_d;
      pac_y_q    <= pac_y_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wall.wall_req = (state_q == S_WAIT);
  assign wall.wall_x   = cand_x_q;
  assign wall.wall_y   = cand_y_q;
  assign pac_x_o       = pac_x_q;
  assign pac_y_o       = pac_y_q;
  assign dir_o         = dir_q;
  assign moving_o      = moving_q;
  assign pos_upd_o     = (state_q == S_COMMIT);

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Bench for pac_move_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pac_move_ctrl;
  localparam int STEP = 2, X_MAX = 608, Y_MAX = 448, X_INIT = 30, Y_INIT = 146, TMO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       kp_ready = 1'b0;
  logic [4:0] kp_code = 5'd0;
  logic       ps2_ready = 1'b0;
  logic [9:0] ps2_data = 10'd0;
  logic       tick = 1'b0;
  logic [9:0] pac_x;
  logic [8:0] pac_y;
  logic [1:0] dir;
  logic       moving, pos_upd;

  pac_move_ctrl_if wall_if();

  always #5 clk = ~clk;

  pac_move_ctrl #(.STEP(STEP), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(X_INIT),
                  .Y_INIT(Y_INIT), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .kp_ready_i(kp_ready), .kp_code_i(kp_code),
    .ps2_ready_i(ps2_ready), .ps2_data_i(ps2_data), .tick_i(tick),
    .wall(wall_if), .pac_x_o(pac_x), .pac_y_o(pac_y), .dir_o(dir),
    .moving_o(moving), .pos_upd_o(pos_upd));

  int checks = 0, failures = 0;
  bit cmp_en = 0;

  // Model: position, heading, moving flag, and the move in progress
  // (phase 0 none, 1 candidate pending, 2 asking the map, 3 applying).
  int m_x, m_y, m_dir, m_mov, m_phase, m_cx, m_cy, m_waited;
  bit m_kp_prev, m_ps2_prev;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int kp_decode(input logic [4:0] c);
    case (c)
      5'h0E: return 0;
      5'h0C: return 1;
      5'h09: return 2;
      5'h11: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int ps2_decode(input logic [9:0] d);
    if (d[8]) return -1;
    case (d[7:0])
      8'h74: return 0;
      8'h6B: return 1;
      8'h75: return 2;
      8'h72: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    int kd, pd, key, nx, ny;
    if (!rst) begin
      m_x = X_INIT; m_y = Y_INIT; m_dir = 0; m_mov = 0; m_phase = 0;
      m_kp_prev = 0; m_ps2_prev = 0; m_waited = 0;
    end else begin
      kd  = (kp_ready && !m_kp_prev) ? kp_decode(kp_code) : -1;
      pd  = (ps2_ready && !m_ps2_prev) ? ps2_decode(ps2_data) : -1;
      key = (kd >= 0) ? kd : pd;
      if (m_phase == 0) begin
        if (tick && m_mov != 0) m_phase = 1;
      end else if (m_phase == 1) begin
        nx = m_x; ny = m_y;
        if (m_dir == 0) nx = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
        else if (m_dir == 1) nx = (m_x < STEP) ? 0 : m_x - STEP;
        else if (m_dir == 2) ny = (m_y < STEP) ? 0 : m_y - STEP;
        else ny = (m_y + STEP > Y_MAX) ? Y_MAX : m_y + STEP;
        if (nx == m_x && ny == m_y) begin
          m_mov = 0; m_phase = 0;
        end else begin
          m_cx = nx; m_cy = ny; m_waited = 0; m_phase = 2;
        end
      end else if (m_phase == 2) begin
        if (wall_if.wall_ack) begin
          if (wall_if.wall_hit) begin m_mov = 0; m_phase = 0; end
          else m_phase = 3;
        end else begin
          m_waited++;
          if (m_waited == TMO) begin m_mov = 0; m_phase = 0; end
        end
      end else begin
        m_x = m_cx; m_y = m_cy; m_phase = 0;
      end
      if (key >= 0) begin m_dir = key; m_mov = 1; end
      m_kp_prev = kp_ready;
      m_ps2_prev = ps2_ready;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pac_x", int'(pac_x), m_x);
      chk("pac_y", int'(pac_y), m_y);
      chk("dir", int'(dir), m_dir);
      chk("moving", int'(moving), m_mov);
      chk("wall_req", int'(wall_if.wall_req), (m_phase == 2) ? 1 : 0);
      chk("pos_upd", int'(pos_upd), (m_phase == 3) ? 1 : 0);
      if (m_phase == 2) begin
        chk("wall_x", int'(wall_if.wall_x), m_cx);
        chk("wall_y", int'(wall_if.wall_y), m_cy);
      end
    end
  end

  logic [4:0] kp_tab [8];
  logic [7:0] ps2_tab [8];
  int n;

  initial begin
    wall_if.wall_ack = 1'b0;
    wall_if.wall_hit = 1'b0;
    kp_tab  = '{5'h0C, 5'h0E, 5'h09, 5'h11, 5'h0E, 5'h11, 5'h03, 5'h1F};
    ps2_tab = '{8'h6B, 8'h74, 8'h75, 8'h72, 8'h74, 8'h72, 8'h1C, 8'hF0};

    // Reset state
    rst = 1'b0;
    cyc(2);
    cmp_en = 1;
    chk("rst_pac_x", int'(pac_x), 30);
    chk("rst_pac_y", int'(pac_y), 146);
    chk("rst_moving", int'(moving), 0);
    chk("rst_wall_req", int'(wall_if.wall_req), 0);
    rst = 1'b1;
    cyc(1);

    // Keypad right, tick, immediate free ack: pos_upd 3 cycles after tick
    kp_code = 5'h0E; kp_ready = 1'b1;
    cyc(1);
    kp_ready = 1'b0;
    chk("kp_right_dir", int'(dir), 0);
    chk("kp_right_moving", int'(moving), 1);
    wall_if.wall_ack = 1'b1; wall_if.wall_hit = 1'b0;
    tick = 1'b1; cyc(1); tick = 1'b0;
    cyc(2);
    chk("upd_pulse", int'(pos_upd), 1);
    cyc(1);
    chk("upd_done", int'(pos_upd), 0);
    chk("moved_x", int'(pac_x), 32);

    // Wall hit: position kept, moving cleared
    wall_if.wall_hit = 1'b1;
    tick = 1'b1; cyc(1); tick = 1'b0;
    cyc(3);
    chk("hit_x", int'(pac_x), 32);
    chk("hit_moving", int'(moving), 0);

    // PS/2 break code is ignored
    ps2_data = {2'b01, 8'h6B}; ps2_ready = 1'b1;
    cyc(1);
    ps2_ready = 1'b0;
    tick = 1'b1; cyc(1); tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("break_no_req", int'(wall_if.wall_req), 0);
      cyc(1);
    end
    chk("break_moving", int'(moving), 0);
    chk("break_dir", int'(dir), 0);

    // No ack at all: request held for the timeout, then treated as hit
    kp_code = 5'h0E; kp_ready = 1'b1;
    cyc(1);
    kp_ready = 1'b0;
    wall_if.wall_ack = 1'b0;
    tick = 1'b1; cyc(1); tick = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (wall_if.wall_req) n++;
      else if (n > 0) break;
    end
    chk("timeout_req_cycles", n, 15);
    chk("timeout_moving", int'(moving), 0);
    chk("timeout_x", int'(pac_x), 32);

    // Simultaneous keypad up and PS/2 right: keypad wins
    kp_code = 5'h09; kp_ready = 1'b1;
    ps2_data = {2'b00, 8'h74}; ps2_ready = 1'b1;
    cyc(1);
    kp_ready = 1'b0; ps2_ready = 1'b0;
    chk("both_dir", int'(dir), 2);

    // Walk up to the top edge, then one more tick does nothing
    wall_if.wall_ack = 1'b1; wall_if.wall_hit = 1'b0;
    for (int i = 0; i < 73; i++) begin
      tick = 1'b1; cyc(1); tick = 1'b0;
      cyc(3);
    end
    chk("top_y", int'(pac_y), 0);
    chk("top_moving_before", int'(moving), 1);
    tick = 1'b1; cyc(1); tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("top_no_req", int'(wall_if.wall_req), 0);
      cyc(1);
    end
    chk("top_moving_after", int'(moving), 0);
    chk("top_y_kept", int'(pac_y), 0);

    // Reset while waiting on the map
    kp_code = 5'h11; kp_ready = 1'b1;
    cyc(1);
    kp_ready = 1'b0;
    wall_if.wall_ack = 1'b0;
    tick = 1'b1; cyc(1); tick = 1'b0;
    cyc(1);
    chk("pre_rst_req", int'(wall_if.wall_req), 1);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    chk("mid_rst_req", int'(wall_if.wall_req), 0);
    chk("mid_rst_x", int'(pac_x), 30);
    chk("mid_rst_y", int'(pac_y), 146);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 6) == 0) kp_ready = ~kp_ready;
      kp_code = kp_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 8) == 0) ps2_ready = ~ps2_ready;
      ps2_data = {1'b0, ($urandom_range(0, 3) == 0), ps2_tab[$urandom_range(0, 7)]};
      tick = ($urandom_range(0, 4) == 0);
      wall_if.wall_ack = ($urandom_range(0, 2) == 0);
      wall_if.wall_hit = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 599) != 0);
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
